// File: rtl/irq_latency_meter.sv
// IRQ flag pulse-width meter: synchronizes an external flag, times each high pulse
// in clk cycles and exposes last/min/max/count/sum statistics over Avalon-MM.
module irq_latency_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PULSE   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        irqflag_in,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        meas_busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HIGH     = 2'd1,
        COMMIT   = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_PULSE);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   s_d_q;
    logic                   armed_q;
    logic                   s;
    logic                   rise;
    logic                   fall;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             commit;
    logic             ovf_hit;

    logic [CNT_W-1:0] last_q;
    logic [CNT_W-1:0] min_q;
    logic [CNT_W-1:0] max_q;
    logic [31:0]      count_q;
    logic [63:0]      sum_q;
    logic [7:0]       glitch_q;
    logic             valid_q;
    logic             ovf_q;
    logic             enable_q;
    logic [31:0]      readdata_q;
    logic [31:0]      rd_mux;

    logic ctrl_wr;
    logic clr_req;
    logic dis_req;
    logic unused_wdata;

    assign ctrl_wr      = avs_write && (avs_address == 3'd7);
    assign clr_req      = ctrl_wr && avs_writedata[0];
    assign dis_req      = ctrl_wr && !avs_writedata[1];
    assign unused_wdata = ^avs_writedata[31:2];

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s && !s_d_q;
    assign fall = !s && s_d_q;

    // prime_q marks when the synchronizer output reflects the real pin; a flag
    // already high at reset release must go low once before a rise is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            prime_q <= '0;
            s_d_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], irqflag_in};
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            s_d_q   <= s;
            if (prime_q[SYNC_STAGES-1] && !s) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        ovf_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise && armed_q && enable_q) begin
                    state_d = HIGH;
                    cnt_d   = CNT_W'(1);
                end
            end
            HIGH: begin
                if (clr_req || dis_req) begin
                    state_d = WAIT_LOW;
                end else if (fall) begin
                    state_d = COMMIT;
                end else begin
                    ovf_hit = (cnt_q == CNT_MAX);
                    cnt_d   = sat_inc_cnt(cnt_q);
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            WAIT_LOW: begin
                if (!s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign meas_busy = (state_q == HIGH);

    // A clear in the same cycle as COMMIT takes priority and drops that sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q   <= '0;
            min_q    <= CNT_MAX;
            max_q    <= '0;
            count_q  <= '0;
            sum_q    <= '0;
            glitch_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            enable_q <= 1'b1;
        end else begin
            if (ctrl_wr) begin
                enable_q <= avs_writedata[1];
            end
            if (clr_req) begin
                last_q   <= '0;
                min_q    <= CNT_MAX;
                max_q    <= '0;
                count_q  <= '0;
                sum_q    <= '0;
                glitch_q <= '0;
                valid_q  <= 1'b0;
                ovf_q    <= 1'b0;
            end else begin
                if (ovf_hit) begin
                    ovf_q <= 1'b1;
                end
                if (commit) begin
                    if (cnt_q >= MIN_LEN) begin
                        last_q  <= cnt_q;
                        min_q   <= (cnt_q < min_q) ? cnt_q : min_q;
                        max_q   <= (cnt_q > max_q) ? cnt_q : max_q;
                        count_q <= sat_inc32(count_q);
                        sum_q   <= sum_q + 64'(cnt_q);
                        valid_q <= 1'b1;
                    end else begin
                        glitch_q <= sat_inc8(glitch_q);
                    end
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            3'd0:    rd_mux = {16'd0, glitch_q, 4'd0, meas_busy, enable_q, ovf_q, valid_q};
            3'd1:    rd_mux = 32'(last_q);
            3'd2:    rd_mux = 32'(min_q);
            3'd3:    rd_mux = 32'(max_q);
            3'd4:    rd_mux = count_q;
            3'd5:    rd_mux = sum_q[31:0];
            3'd6:    rd_mux = sum_q[63:32];
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= avs_read ? rd_mux : 32'd0;
        end
    end

    assign avs_readdata = readdata_q;

endmodule
